// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the pipelined multiply unit
package mult_pkg;

  // RV32M multiply variants, encoded as their funct3 values
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3
  } mult_op_e;

  // rs1 is treated as signed for MULH and MULHSU
  function automatic logic op1_is_signed(input logic [2:0] funct3);
    return (funct3 == MULH) || (funct3 == MULHSU);
  endfunction

  // rs2 is treated as signed only for MULH
  function automatic logic op2_is_signed(input logic [2:0] funct3);
    return (funct3 == MULH);
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// rtl/mult_pipe_stage.sv - one valid/ready register slice with flush and reset
module mult_pipe_stage
  import mult_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [XLEN-1:0]  in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_data
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } stage_t;

  stage_t st;

  // The slice can take a new entry when it is empty or its content moves on,
  // which lets bubbles collapse behind a stalled output.
  assign in_ready  = !st.valid || out_ready;
  assign out_valid = st.valid;
  assign out_tag   = st.tag;
  assign out_data  = st.data;

  // Register update: reset clears everything, flush only kills the valid bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= '0;
    end else if (flush) begin
      st.valid <= 1'b0;
    end else if (in_ready) begin
      st.valid <= in_valid;
      if (in_valid) begin
        st.tag  <= in_tag;
        st.data <= in_data;
      end
    end
  end

endmodule

// File: rtl/mult_pipe_unit.sv
// rtl/mult_pipe_unit.sv - pipelined RV32M multiply unit with CDB handshake; option MULT_EARLY_TAG_EN
module mult_pipe_unit
  import mult_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 6,
  parameter int LATENCY = 3,
  parameter int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [XLEN-1:0]  op1,
  input  logic [XLEN-1:0]  op2,
  input  logic [2:0]       funct3,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  input  logic             cdb_grant,
  output logic [XLEN-1:0]  res,
  output logic [TAG_W-1:0] tag_out,
  output logic             tag_out_valid,
  output logic [CNT_W-1:0] occupancy,
`ifdef MULT_EARLY_TAG_EN
  output logic [TAG_W-1:0] early_tag,
  output logic             early_tag_valid,
`endif
  output logic             branch,
  output logic             branch_taken,
  output logic             jalr,
  output logic             store_pc
);

  if (LATENCY < 1) begin : g_bad_latency
    $error("mult_pipe_unit: LATENCY must be at least 1");
  end

  assign branch       = 1'b0;
  assign branch_taken = 1'b0;
  assign jalr         = 1'b0;
  assign store_pc     = 1'b0;

  logic signed [XLEN:0]       a_ext;
  logic signed [XLEN:0]       b_ext;
  logic signed [2*XLEN+1:0]   prod;
  logic [XLEN-1:0]            prod_sel;
  logic                       unused_prod_top;

  // Product stage: one signed (XLEN+1)x(XLEN+1) multiply covers all variants
  always_comb begin
    a_ext = {op1_is_signed(funct3) & op1[XLEN-1], op1};
    b_ext = {op2_is_signed(funct3) & op2[XLEN-1], op2};
    prod  = a_ext * b_ext;
    case (funct3)
      MUL:                 prod_sel = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: prod_sel = prod[2*XLEN-1:XLEN];
      default:             prod_sel = '0;
    endcase
  end

  assign unused_prod_top = ^prod[2*XLEN+1:2*XLEN];

  logic             stg_valid [LATENCY];
  logic [TAG_W-1:0] stg_tag   [LATENCY];
  logic [XLEN-1:0]  stg_data  [LATENCY];
  logic             stg_ready [LATENCY+1];
  logic             in_valid  [LATENCY];
  logic [TAG_W-1:0] in_tag    [LATENCY];
  logic [XLEN-1:0]  in_data   [LATENCY];

  assign stg_ready[LATENCY] = cdb_grant;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign in_valid[i] = issue_valid;
      assign in_tag[i]   = tag_in;
      assign in_data[i]  = prod_sel;
    end else begin : g_rest
      assign in_valid[i] = stg_valid[i-1];
      assign in_tag[i]   = stg_tag[i-1];
      assign in_data[i]  = stg_data[i-1];
    end

    mult_pipe_stage #(
      .XLEN  (XLEN),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid[i]),
      .in_tag    (in_tag[i]),
      .in_data   (in_data[i]),
      .in_ready  (stg_ready[i]),
      .out_ready (stg_ready[i+1]),
      .out_valid (stg_valid[i]),
      .out_tag   (stg_tag[i]),
      .out_data  (stg_data[i])
    );
  end

  logic capture;
  logic retire;

  assign issue_ready   = stg_ready[0];
  assign res           = stg_data[LATENCY-1];
  assign tag_out       = stg_tag[LATENCY-1];
  assign tag_out_valid = stg_valid[LATENCY-1];
  assign capture       = issue_valid && issue_ready && !flush;
  assign retire        = tag_out_valid && cdb_grant;

  // Occupancy tracks entries in flight; it mirrors the popcount of stage valids
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      occupancy <= '0;
    end else begin
      case ({capture, retire})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef MULT_EARLY_TAG_EN
  if (LATENCY < 2) begin : g_early_bad
    $error("mult_pipe_unit: MULT_EARLY_TAG_EN needs LATENCY of at least 2");
    assign early_tag       = '0;
    assign early_tag_valid = 1'b0;
  end else begin : g_early
    logic flush_q;

    // Remember a flush so the early request stays quiet the cycle after it
    always_ff @(posedge clk) begin
      if (!rst) begin
        flush_q <= 1'b0;
      end else begin
        flush_q <= flush;
      end
    end

    assign early_tag       = stg_tag[LATENCY-2];
    assign early_tag_valid = stg_valid[LATENCY-2] && !flush && !flush_q;
  end
`endif

endmodule

// File: tb/tb_mult_pipe_unit.sv
// tb/tb_mult_pipe_unit.sv - directed self-checking bench for mult_pipe_unit
module tb_mult_pipe_unit;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [2:0]  funct3;
  logic [5:0]  tag_in;
  logic        flush;
  logic        cdb_grant;

  logic        ready3, valid3, br3, brt3, jalr3, spc3;
  logic [31:0] res3;
  logic [5:0]  tag3;
  logic [1:0]  occ3;

  logic        ready5, valid5, br5, brt5, jalr5, spc5;
  logic [31:0] res5;
  logic [5:0]  tag5;
  logic [2:0]  occ5;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULT_EARLY_TAG_EN
  logic [5:0] etag3, etag5;
  logic       evalid3, evalid5;
`else
  logic        ready1, valid1, br1, brt1, jalr1, spc1;
  logic [31:0] res1;
  logic [5:0]  tag1;
  logic [0:0]  occ1;

  mult_pipe_unit #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(ready1),
    .op1(op1), .op2(op2), .funct3(funct3), .tag_in(tag_in), .flush(flush),
    .cdb_grant(cdb_grant), .res(res1), .tag_out(tag1), .tag_out_valid(valid1),
    .occupancy(occ1), .branch(br1), .branch_taken(brt1), .jalr(jalr1), .store_pc(spc1)
  );
`endif

  mult_pipe_unit #(.LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(ready3),
    .op1(op1), .op2(op2), .funct3(funct3), .tag_in(tag_in), .flush(flush),
    .cdb_grant(cdb_grant), .res(res3), .tag_out(tag3), .tag_out_valid(valid3),
    .occupancy(occ3),
`ifdef MULT_EARLY_TAG_EN
    .early_tag(etag3), .early_tag_valid(evalid3),
`endif
    .branch(br3), .branch_taken(brt3), .jalr(jalr3), .store_pc(spc3)
  );

  mult_pipe_unit #(.LATENCY(5)) dut5 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(ready5),
    .op1(op1), .op2(op2), .funct3(funct3), .tag_in(tag_in), .flush(flush),
    .cdb_grant(cdb_grant), .res(res5), .tag_out(tag5), .tag_out_valid(valid5),
    .occupancy(occ5),
`ifdef MULT_EARLY_TAG_EN
    .early_tag(etag5), .early_tag_valid(evalid5),
`endif
    .branch(br5), .branch_taken(brt5), .jalr(jalr5), .store_pc(spc5)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  t;
    logic [31:0] e;
  } vec_t;

  vec_t tbl [9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b0; issue_valid = 1'b0; flush = 1'b0; cdb_grant = 1'b0;
    op1 = '0; op2 = '0; funct3 = '0; tag_in = '0;
    tick;
    rst = 1'b1;
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t);
    issue_valid = 1'b1; funct3 = f; op1 = a; op2 = b; tag_in = t;
  endtask

  initial begin
    int n1, n3, n5, got, stalls, seen;
    logic [31:0] r1, r3, r5;
    logic [5:0]  t3;

    tbl[0] = '{3'd0, 32'd7,        32'd6,        6'd5,  32'd42};
    tbl[1] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd1,  32'h00000001};
    tbl[2] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2,  32'h00000000};
    tbl[3] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd3,  32'hFFFFFFFF};
    tbl[4] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd4,  32'hFFFFFFFE};
    tbl[5] = '{3'd5, 32'd123,      32'd456,      6'd9,  32'h00000000};
    tbl[6] = '{3'd1, 32'h80000000, 32'h80000000, 6'd10, 32'h40000000};
    tbl[7] = '{3'd3, 32'h80000000, 32'd4,        6'd11, 32'h00000002};
    tbl[8] = '{3'd0, 32'h12345678, 32'h10,       6'd12, 32'h23456780};

    // Reset state, sampled while rst is still low
    rst = 1'b0; issue_valid = 1'b0; flush = 1'b0; cdb_grant = 1'b0;
    op1 = '0; op2 = '0; funct3 = '0; tag_in = '0;
    tick; tick;
    chk("reset_res", res3, 0);
    chk("reset_tag", tag3, 0);
    chk("reset_valid", valid3, 0);
    chk("reset_occ", occ3, 0);
    chk("const_outs", {br3, brt3, jalr3, spc3}, 0);
    rst = 1'b1;
    #1;
    chk("ready_after_reset", ready3, 1);

    // Single MUL, latency measured on every instance
    cdb_grant = 1'b1;
    drive(3'd0, 32'd7, 32'd6, 6'd5);
    n1 = 0; n3 = 0; n5 = 0; r1 = '0; r3 = '0; r5 = '0; t3 = '0;
    for (int n = 1; n <= 10; n++) begin
      tick;
      issue_valid = 1'b0;
`ifndef MULT_EARLY_TAG_EN
      if (valid1 && n1 == 0) begin n1 = n; r1 = res1; end
`endif
      if (valid3 && n3 == 0) begin n3 = n; r3 = res3; t3 = tag3; end
      if (valid5 && n5 == 0) begin n5 = n; r5 = res5; end
    end
    chk("lat3_cycles", n3, 3);
    chk("lat3_res", r3, 42);
    chk("lat3_tag", t3, 5);
    chk("lat5_cycles", n5, 5);
    chk("lat5_res", r5, 42);
`ifndef MULT_EARLY_TAG_EN
    chk("lat1_cycles", n1, 1);
    chk("lat1_res", r1, 42);
`endif

    // Table of vectors streamed back to back with continuous grant
    do_reset;
    cdb_grant = 1'b1;
    got = 0; stalls = 0;
    for (int c = 0; c < 9 + 8; c++) begin
      if (c < 9) begin
        drive(tbl[c].f, tbl[c].a, tbl[c].b, tbl[c].t);
        if (!ready3) stalls++;
      end else begin
        issue_valid = 1'b0;
      end
      tick;
      if (valid3) begin
        if (got < 9) begin
          chk($sformatf("vec%0d_res", got), res3, tbl[got].e);
          chk($sformatf("vec%0d_tag", got), tag3, tbl[got].t);
        end
        got++;
      end
    end
    chk("stream_count", got, 9);
    chk("stream_stalls", stalls, 0);
    chk("stream_occ_end", occ3, 0);

    // Backpressure: fill with grant low, then drain in order
    do_reset;
    for (int k = 1; k <= 3; k++) begin
      drive(3'd0, k, 32'd10, 6'(k));
      tick;
    end
    drive(3'd0, 32'd4, 32'd10, 6'd4);
    chk("bp_ready_full", ready3, 0);
    chk("bp_occ_full", occ3, 3);
    tick; tick;
    chk("bp_res_stable", res3, 10);
    chk("bp_tag_stable", tag3, 1);
    chk("bp_occ_hold", occ3, 3);
    cdb_grant = 1'b1;
    #1;
    chk("bp_ready_grant", ready3, 1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain%0d_valid", k), valid3, 1);
      chk($sformatf("drain%0d_tag", k), tag3, k);
      chk($sformatf("drain%0d_res", k), res3, k * 10);
      tick;
      issue_valid = 1'b0;
    end
    chk("drain_empty", valid3, 0);
    chk("drain_occ", occ3, 0);

    // Flush with two ops in flight and an issue in the flush cycle
    do_reset;
    drive(3'd0, 32'd2, 32'd3, 6'd11); tick;
    drive(3'd0, 32'd2, 32'd4, 6'd12); tick;
    drive(3'd0, 32'd2, 32'd5, 6'd13);
    flush = 1'b1;
    chk("flush_occ_before", occ3, 2);
    tick;
    flush = 1'b0; issue_valid = 1'b0;
    chk("flush_occ_after", occ3, 0);
    cdb_grant = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (valid3) seen++;
      tick;
    end
    chk("flush_no_result", seen, 0);

    // Reset in the middle of an operation discards it
    do_reset;
    cdb_grant = 1'b1;
    drive(3'd0, 32'd3, 32'd3, 6'd20); tick;
    issue_valid = 1'b0; tick;
    rst = 1'b0; tick;
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (valid3) seen++;
      tick;
    end
    chk("midreset_no_result", seen, 0);
    chk("midreset_occ", occ3, 0);

`ifdef MULT_EARLY_TAG_EN
    // Early tag leads the result by one cycle
    do_reset;
    cdb_grant = 1'b1;
    drive(3'd0, 32'd7, 32'd6, 6'd5);
    n1 = 0; n3 = 0;
    for (int n = 1; n <= 10; n++) begin
      tick;
      issue_valid = 1'b0;
      if (evalid3 && etag3 == 6'd5 && n1 == 0) n1 = n;
      if (valid3 && n3 == 0) n3 = n;
    end
    chk("early_cycle", n1, 2);
    chk("early_lead", n3 - n1, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
